// File: rtl/sdr_scl_monitor.sv
// I2C-style bus monitor: synchronizes raw SCL/SDA, flags edges, START/RSTART/STOP,
// and tracks bus busy / available / idle status from the free-time counter.
module sdr_scl_monitor #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AVAIL_CYCLES = 50,
    parameter int unsigned IDLE_CYCLES  = 10000
) (
    input  logic i_sdr_ctrl_clk,
    input  logic i_sdr_ctrl_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    input  logic i_mon_en,
    output logic o_scl_sync,
    output logic o_sda_sync,
    output logic o_scl_pos_edge,
    output logic o_scl_neg_edge,
    output logic o_start_det,
    output logic o_rstart_det,
    output logic o_stop_det,
    output logic o_bus_busy,
    output logic o_bus_available,
    output logic o_bus_idle
);

    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [0:0] ST_FREE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] AVAIL_THR = CNT_W'(AVAIL_CYCLES);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;

    logic                   scl_pos_q, scl_pos_d;
    logic                   scl_neg_q, scl_neg_d;
    logic                   start_q, start_d;
    logic                   rstart_q, rstart_d;
    logic                   stop_q, stop_d;
    logic                   avail_q, avail_d;
    logic                   idle_q, idle_d;

    logic [0:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   scl_s;
    logic                   sda_s;
    logic                   start_cond;
    logic                   stop_cond;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Bus conditions need SCL high in both the previous and current synced cycle.
    assign start_cond = sda_prev_q & ~sda_s & scl_prev_q & scl_s;
    assign stop_cond  = ~sda_prev_q & sda_s & scl_prev_q & scl_s;

    // Synchronizer chains and history flops run regardless of i_mon_en.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        scl_pos_d  = i_mon_en & scl_s & ~scl_prev_q;
        scl_neg_d  = i_mon_en & ~scl_s & scl_prev_q;
    end

    // Bus state FSM: next state and condition pulses.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        rstart_d = 1'b0;
        stop_d   = 1'b0;
        if (!i_mon_en) begin
            state_d = ST_FREE;
        end else begin
            case (state_q)
                ST_FREE: begin
                    if (start_cond) begin
                        state_d = ST_BUSY;
                        start_d = 1'b1;
                    end else if (stop_cond) begin
                        stop_d = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (start_cond) begin
                        rstart_d = 1'b1;
                    end else if (stop_cond) begin
                        state_d = ST_FREE;
                        stop_d  = 1'b1;
                    end
                end
                default: state_d = ST_FREE;
            endcase
        end
    end

    // Free-time counter and the status levels derived from its next value.
    always_comb begin
        cnt_d = '0;
        if (i_mon_en && (state_q == ST_FREE) && scl_s && sda_s && !stop_cond) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        avail_d = (state_d == ST_FREE) && (cnt_d >= AVAIL_THR);
        idle_d  = (state_d == ST_FREE) && (cnt_d >= CNT_MAX);
    end

    always_ff @(posedge i_sdr_ctrl_clk or negedge i_sdr_ctrl_rst_n) begin
        if (!i_sdr_ctrl_rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_pos_q  <= 1'b0;
            scl_neg_q  <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            avail_q    <= 1'b0;
            idle_q     <= 1'b0;
            state_q    <= ST_FREE;
            cnt_q      <= '0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_pos_q  <= scl_pos_d;
            scl_neg_q  <= scl_neg_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            avail_q    <= avail_d;
            idle_q     <= idle_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_scl_sync      = scl_s;
    assign o_sda_sync      = sda_s;
    assign o_scl_pos_edge  = scl_pos_q;
    assign o_scl_neg_edge  = scl_neg_q;
    assign o_start_det     = start_q;
    assign o_rstart_det    = rstart_q;
    assign o_stop_det      = stop_q;
    assign o_bus_busy      = (state_q == ST_BUSY);
    assign o_bus_available = avail_q;
    assign o_bus_idle      = idle_q;

endmodule

// File: tb/tb_sdr_scl_monitor.sv
// Directed bench for sdr_scl_monitor: expected pulses are queued when the bus
// lines are driven and matched against DUT pulses cycle by cycle.
module tb_sdr_scl_monitor;

    localparam int LAT = 3;
    localparam logic [4:0] EV_POS    = 5'b10000;
    localparam logic [4:0] EV_NEG    = 5'b01000;
    localparam logic [4:0] EV_START  = 5'b00100;
    localparam logic [4:0] EV_RSTART = 5'b00010;
    localparam logic [4:0] EV_STOP   = 5'b00001;
    localparam logic [9:0] RST_OUTS  = 10'b11_0000_0000;

    logic clk = 1'b0;
    logic rst_n, scl, sda, mon_en;
    logic scl_sync, sda_sync, pos_edge, neg_edge;
    logic start_det, rstart_det, stop_det, busy, avail, idle;

    typedef struct {
        int         cyc;
        logic [4:0] ev;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    sdr_scl_monitor dut (
        .i_sdr_ctrl_clk  (clk),
        .i_sdr_ctrl_rst_n(rst_n),
        .i_scl           (scl),
        .i_sda           (sda),
        .i_mon_en        (mon_en),
        .o_scl_sync      (scl_sync),
        .o_sda_sync      (sda_sync),
        .o_scl_pos_edge  (pos_edge),
        .o_scl_neg_edge  (neg_edge),
        .o_start_det     (start_det),
        .o_rstart_det    (rstart_det),
        .o_stop_det      (stop_det),
        .o_bus_busy      (busy),
        .o_bus_available (avail),
        .o_bus_idle      (idle)
    );

    always #10 clk = ~clk;

    function automatic logic [9:0] outs();
        return {scl_sync, sda_sync, pos_edge, neg_edge, start_det,
                rstart_det, stop_det, busy, avail, idle};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic [4:0] ev);
        sb.push_back('{cyc + LAT, ev});
    endtask

    // One clock: outputs are sampled on the falling edge, pulses matched to the queue.
    task automatic tick();
        logic [4:0] obs;
        logic [4:0] exp;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        obs = {pos_edge, neg_edge, start_det, rstart_det, stop_det};
        exp = '0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp = sb[0].ev;
            sb.delete(0);
        end
        if (obs != 5'b0 || exp != 5'b0) chk("pulse", 32'(obs), 32'(exp));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0; scl = 1'b1; sda = 1'b1; mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(RST_OUTS));
        rst_n = 1'b1;

        // Released bus: available after 50 clocks, idle after 10000.
        for (int i = 0; i < 10010; i++) begin
            tick();
            if (cyc == 49 || cyc == 50 || cyc == 60)
                chk("avail_thr", 32'(avail), 32'(cyc >= 50));
            if (cyc == 60 || cyc == 9999 || cyc == 10000 || cyc == 10010)
                chk("idle_thr", 32'(idle), 32'(cyc >= 10000));
        end

        // START from FREE.
        sda = 1'b0; expect_ev(EV_START); ticks(LAT);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("avail_after_start", 32'(avail), 32'd0);
        chk("idle_after_start", 32'(idle), 32'd0);

        // Nine SCL periods, 2 high / 2 low.
        for (int k = 0; k < 9; k++) begin
            scl = 1'b0; expect_ev(EV_NEG); ticks(2);
            scl = 1'b1; expect_ev(EV_POS); ticks(2);
        end
        ticks(2);

        // Repeated START while BUSY.
        scl = 1'b0; expect_ev(EV_NEG); ticks(4);
        sda = 1'b1; ticks(4);
        scl = 1'b1; expect_ev(EV_POS); ticks(4);
        sda = 1'b0; expect_ev(EV_RSTART); ticks(4);
        chk("busy_after_rstart", 32'(busy), 32'd1);

        // STOP returns to FREE; counter restarts from zero.
        sda = 1'b1; expect_ev(EV_STOP); ticks(LAT);
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("avail_after_stop", 32'(avail), 32'd0);
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 49) chk("avail_restart_49", 32'(avail), 32'd0);
            if (i == 50) chk("avail_restart_50", 32'(avail), 32'd1);
        end

        // SCL and SDA fall together: edge only, no START.
        scl = 1'b0; sda = 1'b0; expect_ev(EV_NEG); ticks(4);
        chk("busy_after_simul", 32'(busy), 32'd0);
        chk("avail_after_simul", 32'(avail), 32'd0);
        scl = 1'b1; expect_ev(EV_POS); ticks(4);
        sda = 1'b1; expect_ev(EV_STOP); ticks(4);
        chk("busy_after_free_stop", 32'(busy), 32'd0);

        // Monitor disabled: bus activity produces nothing, re-enable is clean.
        mon_en = 1'b0;
        sda = 1'b0; ticks(4);
        chk("busy_disabled", 32'(busy), 32'd0);
        scl = 1'b0; ticks(4);
        scl = 1'b1; ticks(4);
        sda = 1'b1; ticks(4);
        chk("sync_while_disabled", 32'({scl_sync, sda_sync}), 32'd3);
        mon_en = 1'b1; ticks(4);
        sda = 1'b0; expect_ev(EV_START); ticks(LAT);
        chk("busy_after_reenable", 32'(busy), 32'd1);

        // Asynchronous reset while BUSY.
        rst_n = 1'b0;
        #1;
        chk("reset_midbusy", 32'(outs()), 32'(RST_OUTS));
        sda = 1'b1; ticks(3);
        chk("reset_held", 32'(outs()), 32'(RST_OUTS));
        rst_n = 1'b1; ticks(6);
        chk("busy_after_reset", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdr_scl_monitor.md
SDR_SCL_MONITOR -- requirements
Module: sdr_scl_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for i_scl/i_sda; legal range 2..3.
REQ-002 Parameter AVAIL_CYCLES, default 50: bus-available threshold in clocks (1 us at 50 MHz).
REQ-003 Parameter IDLE_CYCLES, default 10000: bus-idle threshold in clocks (200 us at 50 MHz); 14-bit counter.
REQ-004 i_sdr_ctrl_clk  in  1  50 MHz system clock.
REQ-005 i_sdr_ctrl_rst_n  in  1  reset: asynchronous, active-low.
REQ-006 i_scl  in  1  raw bus SCL, asynchronous to clock.
REQ-007 i_sda  in  1  raw bus SDA, asynchronous to clock.
REQ-008 i_mon_en  in  1  1: monitor active; 0: detectors disabled.
REQ-009 o_scl_sync  out  1  synchronized SCL level.
REQ-010 o_sda_sync  out  1  synchronized SDA level.
REQ-011 o_scl_pos_edge  out  1  one-cycle pulse on SCL rising edge.
REQ-012 o_scl_neg_edge  out  1  one-cycle pulse on SCL falling edge.
REQ-013 o_start_det  out  1  one-cycle pulse: START from FREE state.
REQ-014 o_rstart_det  out  1  one-cycle pulse: Repeated START in BUSY state.
REQ-015 o_stop_det  out  1  one-cycle pulse: STOP.
REQ-016 o_bus_busy  out  1  level, 1 while FSM in BUSY.
REQ-017 o_bus_available  out  1  level, bus free >= AVAIL_CYCLES.
REQ-018 o_bus_idle  out  1  level, bus free >= IDLE_CYCLES.

Function
REQ-019 Each of i_scl, i_sda SHALL pass through a SYNC_STAGES flop chain; last stage = o_scl_sync/o_sda_sync; one further flop per line holds previous synced value (scl_prev, sda_prev).
REQ-020 Edge pulses SHALL be registered: o_scl_pos_edge = scl_sync & ~scl_prev, o_scl_neg_edge = ~scl_sync & scl_prev; latency SYNC_STAGES+1 clock edges from first sampling edge of raw transition.
REQ-021 START/RSTART condition SHALL be sda_prev=1, sda_sync=0, scl_prev=1, scl_sync=1; STOP condition SHALL be sda_prev=0, sda_sync=1, scl_prev=1, scl_sync=1; detect pulses registered, same latency as edge pulses.
REQ-022 SCL and SDA changing in the same synced cycle SHALL produce neither START nor STOP (SCL must be high in both cycles); SCL edge pulse still generated.
REQ-023 FSM states FREE, BUSY: FREE + START -> BUSY with o_start_det; BUSY + START -> BUSY with o_rstart_det; BUSY + STOP -> FREE with o_stop_det; FREE + STOP -> FREE with o_stop_det; all else hold.
REQ-024 Free counter SHALL increment by 1 per clock in FREE while scl_sync=1 and sda_sync=1, saturating at IDLE_CYCLES; cleared to 0 on any cycle where either is 0, on STOP, or in BUSY.
REQ-025 o_bus_available SHALL be registered (count >= AVAIL_CYCLES) in FREE; o_bus_idle registered (count >= IDLE_CYCLES); both 0 in BUSY.
REQ-026 i_mon_en=0 SHALL force FSM to FREE, counter to 0, and start/rstart/stop/edge pulses to 0; synchronizer chains keep running; resuming with i_mon_en=1 SHALL not emit spurious pulses in the first cycle (scl_prev/sda_prev stay updated).
REQ-027 Pulses SHALL never exceed one clock for a single bus transition.

Reset
REQ-028 On reset all sync/prev flops SHALL be 1 (bus released), FSM FREE, counter 0, all pulse outputs 0, o_bus_busy 0, o_bus_available 0, o_bus_idle 0, o_scl_sync 1, o_sda_sync 1.
REQ-029 Reset asserted mid-transfer SHALL return to REQ-028 values immediately; after release, no START reported until a new SDA fall with SCL high.

Verification
REQ-030 Reset, SCL=SDA=1 held 60 clocks -> o_bus_available rises after count reaches 50; o_bus_idle stays 0; held 10010 clocks -> o_bus_idle=1, counter saturated at 10000.
REQ-031 From FREE, SDA 1->0 with SCL=1 -> o_start_det pulse 1 clock at edge 3 after sample, o_bus_busy=1, o_bus_available=0.
REQ-032 Toggle SCL 12.5 MHz (2 high/2 low) for 9 cycles -> 9 pos and 9 neg pulses, each 1 clock, spacing 4 clocks.
REQ-033 In BUSY, SDA fall with SCL high -> o_rstart_det pulse, o_start_det 0; then SDA rise with SCL high -> o_stop_det, FSM FREE, counter restarts from 0.
REQ-034 SCL and SDA fall in same clock -> o_scl_neg_edge only, no o_start_det; reset asserted while BUSY -> all outputs at REQ-028 values next cycle.
